// File: rtl/tan_batch_driver_pkg.sv
// Shared definitions for the tan batch driver and the accelerator controller:
// FSM state encoding and default widths/limits.
package tan_batch_driver_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int DEPTH_LOG2_DEF = 3;
  localparam int TMO_CYC_DEF    = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ARM,
    ST_PULSE,
    ST_WAIT,
    ST_STORE,
    ST_DONE
  } state_e;

  // States in which an accelerator operation is in flight and time is charged.
  function automatic logic in_op_window(input state_e s);
    return (s == ST_ARM) || (s == ST_PULSE) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/tan_batch_driver_tmo_counter.sv
// Per-operation watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the LIMIT-th enabled cycle is being spent.
module tmo_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tan_batch_driver.sv
// Batch driver: streams operands from a buffer through a start/busy
// accelerator handshake and writes each result back, with a per-operand timeout.
module tan_batch_driver
  import tan_batch_driver_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int TMO_CYC    = TMO_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2-1:0] x_rd_addr,
  input  logic [DATA_W-1:0]     x_rd_data,
  output logic [DATA_W-1:0]     acc_x,
  output logic                  acc_start,
  input  logic                  acc_ready,
  input  logic                  acc_busy,
  input  logic [DATA_W-1:0]     acc_result,
  output logic                  res_we,
  output logic [DEPTH_LOG2-1:0] res_addr,
  output logic [DATA_W-1:0]     res_data,
  output logic                  batch_busy,
  output logic                  done,
  output logic                  tmo_err
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(1 << DEPTH_LOG2);

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  arm_first_q, arm_first_d;
  logic [DEPTH_LOG2-1:0] x_rd_addr_q, x_rd_addr_d;
  logic [DATA_W-1:0]     acc_x_q, acc_x_d;
  logic                  acc_start_q, acc_start_d;
  logic                  res_we_q, res_we_d;
  logic [DEPTH_LOG2-1:0] res_addr_q, res_addr_d;
  logic [DATA_W-1:0]     res_data_q, res_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  tmo_expired;

  tmo_counter #(
    .LIMIT(TMO_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_FETCH),
    .enable (in_op_window(state_q)),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    arm_first_d = 1'b0;
    acc_x_d     = acc_x_q;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;
    tmo_err_d   = tmo_err_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          cnt_d     = sat_count(count);
          idx_d     = '0;
          tmo_err_d = 1'b0;
          state_d   = (sat_count(count) == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d     = ST_ARM;
        arm_first_d = 1'b1;
      end
      ST_ARM: begin
        // Read data from the FETCH address is valid only in the first ARM cycle.
        if (arm_first_q) acc_x_d = x_rd_data;
        if (tmo_expired) begin
          tmo_err_d = 1'b1;
          state_d   = ST_DONE;
        end else if (acc_ready) begin
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (tmo_expired) begin
          tmo_err_d = 1'b1;
          state_d   = ST_DONE;
        end else if (acc_busy) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tmo_expired) begin
          tmo_err_d = 1'b1;
          state_d   = ST_DONE;
        end else if (!acc_busy) begin
          res_addr_d = idx_q[DEPTH_LOG2-1:0];
          res_data_d = acc_result;
          idx_d      = idx_q + CNT_W'(1);
          state_d    = ST_STORE;
        end
      end
      ST_STORE: state_d = (idx_q == cnt_q) ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    x_rd_addr_d = (state_d == ST_FETCH) ? idx_d[DEPTH_LOG2-1:0] : x_rd_addr_q;
    acc_start_d = (state_d == ST_PULSE);
    res_we_d    = (state_d == ST_STORE);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      arm_first_q <= 1'b0;
      x_rd_addr_q <= '0;
      acc_x_q     <= '0;
      acc_start_q <= 1'b0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      arm_first_q <= arm_first_d;
      x_rd_addr_q <= x_rd_addr_d;
      acc_x_q     <= acc_x_d;
      acc_start_q <= acc_start_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign x_rd_addr  = x_rd_addr_q;
  assign acc_x      = acc_x_q;
  assign acc_start  = acc_start_q;
  assign res_we     = res_we_q;
  assign res_addr   = res_addr_q;
  assign res_data   = res_data_q;
  assign batch_busy = busy_q;
  assign done       = done_q;
  assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_tan_batch_driver.sv
// Directed bench for tan_batch_driver with an operand buffer and a simple
// start/busy accelerator model computing 3*x+7 after a programmable busy time.
module tb_tan_batch_driver;

  logic        clk = 1'b0;
  logic        rst, go;
  logic [3:0]  count;
  logic [2:0]  x_rd_addr;
  logic [15:0] x_rd_data;
  logic [15:0] acc_x;
  logic        acc_start, acc_ready, acc_busy;
  logic [15:0] acc_result;
  logic        res_we;
  logic [2:0]  res_addr;
  logic [15:0] res_data;
  logic        batch_busy, done, tmo_err;

  int errors = 0;
  int checks = 0;

  tan_batch_driver #(.DATA_W(16), .DEPTH_LOG2(3), .TMO_CYC(255)) dut (
    .clk(clk), .rst(rst), .go(go), .count(count),
    .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .acc_x(acc_x), .acc_start(acc_start), .acc_ready(acc_ready),
    .acc_busy(acc_busy), .acc_result(acc_result),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .batch_busy(batch_busy), .done(done), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  // Operand buffer, synchronous read
  logic [15:0] mem [8];
  always @(posedge clk) x_rd_data <= mem[x_rd_addr];

  // Accelerator model: busy for busy_len cycles, result = 3*x+7
  int          busy_len = 10;
  int          rem;
  logic [15:0] x_lat;
  always @(posedge clk) begin
    if (rst) begin
      acc_busy   <= 1'b0;
      acc_ready  <= 1'b1;
      acc_result <= '0;
      rem        <= 0;
      x_lat      <= '0;
    end else if (!acc_busy && acc_start) begin
      acc_busy  <= 1'b1;
      acc_ready <= 1'b0;
      rem       <= busy_len - 1;
      x_lat     <= acc_x;
    end else if (acc_busy) begin
      if (rem == 0) begin
        acc_busy   <= 1'b0;
        acc_ready  <= 1'b1;
        acc_result <= x_lat * 16'd3 + 16'd7;
      end else begin
        rem <= rem - 1;
      end
    end
  end

  // Monitors sample away from the active edge
  logic [2:0]  wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int done_cnt = 0;
  int start_cnt = 0;
  always @(negedge clk) begin
    if (res_we) begin
      wr_addr_q.push_back(res_addr);
      wr_data_q.push_back(res_data);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (acc_start) start_cnt <= start_cnt + 1;
  end

  task automatic start_go(input logic [3:0] c);
    @(negedge clk);
    go = 1'b1;
    count = c;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; count = '0;
    repeat (3) @(negedge clk);
    checks++; if (batch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", batch_busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", acc_start); end
    checks++; if ({res_we, res_addr, res_data} !== 20'd0) begin errors++; $display("FAIL reset_res got=%h exp=0", {res_we, res_addr, res_data}); end
    checks++; if ({x_rd_addr, acc_x, tmo_err} !== 20'd0) begin errors++; $display("FAIL reset_misc got=%h exp=0", {x_rd_addr, acc_x, tmo_err}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int base, dbase, cyc;
    logic [15:0] exp_d [3];
    exp_d[0] = 16'd10; exp_d[1] = 16'd13; exp_d[2] = 16'd16;
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3;
    busy_len = 10;
    base = wr_addr_q.size(); dbase = done_cnt;
    start_go(4'd3);
    checks++; if (batch_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", batch_busy); end
    wait_done(200, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL basic_timeout got=no_done exp=done"); end
    @(negedge clk);
    checks++; if (wr_addr_q.size() - base != 3) begin errors++; $display("FAIL basic_nwr got=%0d exp=3", wr_addr_q.size() - base); end
    for (int i = 0; i < 3 && base + i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[base+i] !== 3'(i)) begin errors++; $display("FAIL basic_addr%0d got=%0d exp=%0d", i, wr_addr_q[base+i], i); end
      checks++; if (wr_data_q[base+i] !== exp_d[i]) begin errors++; $display("FAIL basic_data%0d got=%0d exp=%0d", i, wr_data_q[base+i], exp_d[i]); end
    end
    checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL basic_ndone got=%0d exp=1", done_cnt - dbase); end
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL basic_tmo got=%b exp=0", tmo_err); end
  endtask

  task automatic test_zero();
    int base, sbase;
    base = wr_addr_q.size(); sbase = start_cnt;
    start_go(4'd0);
    // go cycle, then the DONE cycle
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    repeat (3) @(negedge clk);
    checks++; if (wr_addr_q.size() != base) begin errors++; $display("FAIL zero_nwr got=%0d exp=0", wr_addr_q.size() - base); end
    checks++; if (start_cnt != sbase) begin errors++; $display("FAIL zero_start got=%0d exp=0", start_cnt - sbase); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    go = 1'b1; count = 4'd0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", done); end
    @(negedge clk);
    checks++; if ({done, batch_busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle got=%b exp=00", {done, batch_busy}); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    go = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturate();
    int base, cyc;
    for (int i = 0; i < 8; i++) mem[i] = 16'(i + 10);
    busy_len = 3;
    base = wr_addr_q.size();
    start_go(4'd12);
    wait_done(400, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL sat_timeout got=no_done exp=done"); end
    @(negedge clk);
    checks++; if (wr_addr_q.size() - base != 8) begin errors++; $display("FAIL sat_nwr got=%0d exp=8", wr_addr_q.size() - base); end
    for (int i = 0; i < 8 && base + i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[base+i] !== 3'(i)) begin errors++; $display("FAIL sat_addr%0d got=%0d exp=%0d", i, wr_addr_q[base+i], i); end
      checks++; if (wr_data_q[base+i] !== 16'(3 * (i + 10) + 7)) begin errors++; $display("FAIL sat_data%0d got=%0d exp=%0d", i, wr_data_q[base+i], 3 * (i + 10) + 7); end
    end
  endtask

  task automatic test_timeout();
    int base, dbase;
    mem[0] = 16'd5;
    busy_len = 300;
    base = wr_addr_q.size(); dbase = done_cnt;
    start_go(4'd1);
    // k=1 is FETCH; 255 cycles in ARM/PULSE/WAIT span k=2..256; DONE at k=257
    for (int k = 2; k <= 257; k++) begin
      @(negedge clk);
      if (k == 200) begin
        checks++; if (acc_x !== 16'd5) begin errors++; $display("FAIL tmo_accx got=%0d exp=5", acc_x); end
      end
      if (k == 256) begin
        checks++; if ({tmo_err, done} !== 2'b00) begin errors++; $display("FAIL tmo_early got=%b exp=00", {tmo_err, done}); end
      end
    end
    checks++; if ({tmo_err, done, acc_start} !== 3'b110) begin errors++; $display("FAIL tmo_fire got=%b exp=110", {tmo_err, done, acc_start}); end
    repeat (60) @(negedge clk);
    checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", tmo_err); end
    checks++; if (wr_addr_q.size() != base) begin errors++; $display("FAIL tmo_nwr got=%0d exp=0", wr_addr_q.size() - base); end
    checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL tmo_ndone got=%0d exp=1", done_cnt - dbase); end
    busy_len = 10;
  endtask

  task automatic test_go_ignored();
    int base, dbase, cyc;
    mem[0] = 16'd7; mem[1] = 16'd8;
    base = wr_addr_q.size(); dbase = done_cnt;
    start_go(4'd2);
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL goign_tmo_clr got=%b exp=0", tmo_err); end
    for (int i = 0; i < 50 && !acc_busy; i++) @(negedge clk);
    @(negedge clk);
    go = 1'b1; count = 4'd5;
    @(negedge clk);
    go = 1'b0;
    wait_done(300, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL goign_timeout got=no_done exp=done"); end
    repeat (3) @(negedge clk);
    checks++; if (wr_addr_q.size() - base != 2) begin errors++; $display("FAIL goign_nwr got=%0d exp=2", wr_addr_q.size() - base); end
    if (wr_addr_q.size() - base == 2) begin
      checks++; if (wr_data_q[base+1] !== 16'd31) begin errors++; $display("FAIL goign_data got=%0d exp=31", wr_data_q[base+1]); end
    end
    checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL goign_ndone got=%0d exp=1", done_cnt - dbase); end
  endtask

  task automatic test_reset_mid();
    int base, dbase, cyc;
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3;
    base = wr_addr_q.size();
    start_go(4'd3);
    for (int i = 0; i < 100 && wr_addr_q.size() == base; i++) @(negedge clk);
    for (int i = 0; i < 50 && !acc_busy; i++) @(negedge clk);
    @(negedge clk);
    checks++; if (acc_busy !== 1'b1) begin errors++; $display("FAIL rmid_in_wait got=%b exp=1", acc_busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({batch_busy, done, acc_start, res_we, tmo_err} !== 5'd0) begin errors++; $display("FAIL rmid_ctrl got=%b exp=00000", {batch_busy, done, acc_start, res_we, tmo_err}); end
    checks++; if ({x_rd_addr, acc_x, res_addr, res_data} !== 38'd0) begin errors++; $display("FAIL rmid_data got=%h exp=0", {x_rd_addr, acc_x, res_addr, res_data}); end
    base = wr_addr_q.size(); dbase = done_cnt;
    repeat (20) @(negedge clk);
    checks++; if (wr_addr_q.size() != base || done_cnt != dbase) begin errors++; $display("FAIL rmid_abandon got=wr%0d/done%0d exp=0/0", wr_addr_q.size() - base, done_cnt - dbase); end
    mem[0] = 16'd4;
    start_go(4'd1);
    wait_done(200, cyc);
    checks++; if (cyc < 0) begin errors++; $display("FAIL rmid_timeout got=no_done exp=done"); end
    @(negedge clk);
    checks++; if (wr_addr_q.size() - base != 1) begin errors++; $display("FAIL rmid_nwr got=%0d exp=1", wr_addr_q.size() - base); end
    if (wr_addr_q.size() - base == 1) begin
      checks++; if ({wr_addr_q[base], wr_data_q[base]} !== {3'd0, 16'd19}) begin errors++; $display("FAIL rmid_wr got=%0d/%0d exp=0/19", wr_addr_q[base], wr_data_q[base]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_saturate();
    test_timeout();
    test_go_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tan_batch_driver.md
TAN_BATCH_DRIVER -- requirements
Module: tan_batch_driver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the operand/result width.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 3, meaning the log2 of the operand/result buffer depth (8 entries).
REQ-003 The block SHALL have parameter TMO_CYC, default 255, meaning the maximum cycles allowed per accelerator operation.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 go  in  1  batch request, sampled only in IDLE.
REQ-007 count  in  DEPTH_LOG2+1  number of operands in the batch, latched on accepted go.
REQ-008 x_rd_addr  out  DEPTH_LOG2  operand buffer read address; synchronous read, data valid next cycle.
REQ-009 x_rd_data  in  DATA_W  operand buffer read data.
REQ-010 acc_x  out  DATA_W  operand presented to the accelerator.
REQ-011 acc_start  out  1  accelerator start level.
REQ-012 acc_ready  in  1  accelerator idle indication.
REQ-013 acc_busy  in  1  accelerator computing indication.
REQ-014 acc_result  in  DATA_W  accelerator result, valid when acc_busy falls.
REQ-015 res_we, res_addr[DEPTH_LOG2], res_data[DATA_W]  out  result buffer write port.
REQ-016 batch_busy  out  1  high from accepted go until the DONE cycle.
REQ-017 done  out  1  one-cycle pulse at batch end.
REQ-018 tmo_err  out  1  sticky timeout flag, cleared on the next accepted go.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, ARM, PULSE, WAIT, STORE, DONE.
REQ-020 IDLE: acc_start=0; on go=1, latch count (saturated to 2^DEPTH_LOG2), clear index and tmo_err, go to FETCH; if latched count=0, go to DONE directly.
REQ-021 FETCH: drive x_rd_addr=index for one cycle, go to ARM.
REQ-022 ARM: capture x_rd_data into acc_x on entry; hold acc_start=0 until acc_ready=1, then go to PULSE.
REQ-023 The ARM low-phase SHALL last at least one cycle, so the accelerator observes start low before start high.
REQ-024 PULSE: acc_start=1 until acc_busy=1, then go to WAIT.
REQ-025 WAIT: acc_start=0; on acc_busy=0, go to STORE.
REQ-026 acc_x SHALL stay stable from ARM entry through WAIT exit.
REQ-027 STORE: res_we=1 for exactly one cycle, res_addr=index, res_data=acc_result; increment index.
REQ-028 After STORE: go to DONE if index=count, else go to FETCH.
REQ-029 DONE: done=1 for one cycle, go to IDLE.
REQ-030 Timeout counter SHALL reset on each ARM entry and count cycles spent in ARM, PULSE and WAIT.
REQ-031 On reaching TMO_CYC, the block SHALL set tmo_err, drive acc_start=0, skip the store, and go to DONE.
REQ-032 go while batch_busy=1 SHALL be ignored.
REQ-033 go and DONE in the same cycle SHALL NOT start a new batch; go must be seen in IDLE.
REQ-034 Best-case per-operand latency SHALL be FETCH+ARM+PULSE+WAIT+STORE = 5 cycles plus the accelerator compute time.

Reset
REQ-035 While rst=1 at a clock edge, the state SHALL go to IDLE with index=0, acc_x=0, acc_start=0, res_we=0, res_addr=0, res_data=0, x_rd_addr=0, batch_busy=0, done=0, tmo_err=0.
REQ-036 Reset asserted mid-batch SHALL abandon the batch with no done pulse and no further buffer writes.

Structure
REQ-037 The state encoding and the DATA_W/DEPTH_LOG2/TMO_CYC defaults SHALL live in a shared package reused by the accelerator controller.
REQ-038 The timeout counter SHALL be a sub-module, tmo_counter, with clear, enable and expired signals.

Verification
REQ-039 count=3, operands 1/2/3, accelerator model with a 10-cycle busy -> three res_we pulses at addr 0/1/2 with the model's results, then one done pulse; tmo_err=0.
REQ-040 count=0 with go=1 -> done two cycles after go, no res_we, acc_start never high.
REQ-041 count=12 -> saturated to 8; eight writes, addr 0..7.
REQ-042 Accelerator holds acc_busy high for 300 cycles -> tmo_err=1 after 255 cycles in ARM/PULSE/WAIT, acc_start=0, no write for that operand, done pulses.
REQ-043 rst=1 for 1 cycle during the WAIT of operand 2 -> all outputs at reset values next cycle; a later go=1, count=1 completes normally.
REQ-044 go pulsed during WAIT -> ignored; batch result count unchanged.
